mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum wait cycles for dmem_ready before the stage enters the error state (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 ex_valid  input  1  execute stage holds a valid instruction.
REQ-005 aluOutput  input  32  ALU result / effective address from execute.
REQ-006 exe_registerRtOrZero  input  32  store data from execute, already forwarded.
REQ-007 ex_memRead, ex_memWrite, ex_regWrite, ex_memToReg  input  1 each  control from execute.
REQ-008 ex_destReg  input  5  destination register number.
REQ-009 dmem_req  output  1  data-memory request.
REQ-010 dmem_we  output  1  request is a write.
REQ-011 dmem_addr  output  32  word address; bits [1:0] always 0.
REQ-012 dmem_wdata  output  32  store data.
REQ-013 dmem_ready  input  1  memory completes the current request this cycle.
REQ-014 dmem_rdata  input  32  load data, valid when dmem_ready=1.
REQ-015 mem_stall  output  1  freeze execute and all upstream stages.
REQ-016 mem_memoryData  output  32  forward value to execute (load data or ALU result of the M-register instruction).
REQ-017 mem_misaligned  output  1  one-cycle pulse: M-register memory op has addr[1:0]!=0.
REQ-018 mem_error  output  1  sticky timeout flag.
REQ-019 wb_valid, wb_regWrite  output  1 each  writeback control.
REQ-020 wb_destReg  output  5; wb_result  output  32  writeback register and data.

Function
REQ-021 The M register (valid, aluOut, storeData, control, destReg) SHALL load from ex_* on each clk edge where mem_stall=0, and SHALL hold when mem_stall=1.
REQ-022 m_memop = m_valid & (m_memRead | m_memWrite); m_misaligned = m_memop & (m_aluOut[1:0]!=0).
REQ-023 dmem_req SHALL be m_memop & !m_misaligned & state!=ERR; dmem_we=m_memWrite; dmem_addr={m_aluOut[31:2],2'b00}; dmem_wdata=m_storeData; all stable while the request is held.
REQ-024 mem_stall SHALL be (dmem_req & !dmem_ready) | (state==ERR); zero-wait memory (ready in the request cycle) SHALL cause no stall.
REQ-025 FSM states IDLE, WAIT, ERR. IDLE->WAIT when dmem_req & !dmem_ready; WAIT->IDLE on dmem_ready; WAIT->ERR when the wait counter reaches TIMEOUT with dmem_ready=0; ERR exits only on reset.
REQ-026 The 8-bit wait counter SHALL clear on entry to WAIT and on exit from it, and SHALL increment once per WAIT cycle without wrapping.
REQ-027 A dmem_ready arriving in the same cycle the counter reaches TIMEOUT SHALL take priority (->IDLE, no error).
REQ-028 mem_misaligned SHALL be high for exactly one cycle per misaligned instruction; that instruction completes with no memory access and wb_regWrite forced 0.
REQ-029 mem_memoryData SHALL equal dmem_rdata when m_memRead, else m_aluOut.
REQ-030 On each edge with mem_stall=0: wb_valid<=m_valid; wb_regWrite<=m_valid & m_regWrite & !m_misaligned; wb_destReg<=m_destReg; wb_result<=m_memToReg ? dmem_rdata : m_aluOut.
REQ-031 When mem_stall=1, wb_valid SHALL be 0 on the next cycle (bubble) and the wb_* payload SHALL hold.
REQ-032 ex_valid=0 SHALL load a bubble; a bubble issues no request and never stalls.

Reset
REQ-033 rst_n=0 SHALL immediately clear m_valid, wb_valid, wb_regWrite, mem_error, mem_misaligned, dmem_req, the counter and all payload registers to 0, and set state IDLE, including mid-WAIT or in ERR.
REQ-034 The first edge after rst_n rises SHALL sample ex_* normally.

Verification
REQ-035 Load, addr 0x100, dmem_ready same cycle, rdata 0xDEADBEEF -> no stall; next cycle wb_valid=1, wb_result=0xDEADBEEF.
REQ-036 Store, addr 0x204, data 0x12345678, ready after 3 cycles -> dmem_req/we high 4 cycles, mem_stall=1 for 3 cycles, M register held, then wb_valid=1 with wb_regWrite=0.
REQ-037 Load, addr 0x102 -> mem_misaligned pulses 1 cycle, dmem_req stays 0, wb_regWrite=0, no stall.
REQ-038 TIMEOUT=4, ready never asserted -> mem_error=1 and ERR entered after 4 WAIT cycles, mem_stall stays 1; rst_n low clears all.
REQ-039 rst_n asserted during WAIT of a load -> dmem_req and mem_stall drop immediately; after release a new load completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// Memory pipeline stage: holds the M pipeline register, issues data-memory
// requests, stalls upstream while memory is busy, flags misaligned accesses
// and timeouts, and feeds the writeback register.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   ex_valid                 execute stage holds a valid instruction
//   aluOutput                ALU result / effective address
//   exe_registerRtOrZero     forwarded store data
//   ex_memRead/ex_memWrite   memory control from execute
//   ex_regWrite/ex_memToReg  writeback control from execute
//   ex_destReg               destination register number
//   dmem_req/we/addr/wdata   data-memory request (word aligned)
//   dmem_ready/dmem_rdata    memory completion and load data
//   mem_stall                freeze execute and everything upstream
//   mem_memoryData           forward value to execute
//   mem_misaligned           pulse: M instruction has a misaligned address
//   mem_error                sticky memory timeout flag
//   wb_valid/wb_regWrite     writeback control
//   wb_destReg/wb_result     writeback register and data
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] aluOutput,
    input  logic [31:0] exe_registerRtOrZero,
    input  logic        ex_memRead,
    input  logic        ex_memWrite,
    input  logic        ex_regWrite,
    input  logic        ex_memToReg,
    input  logic [4:0]  ex_destReg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] mem_memoryData,
    output logic        mem_misaligned,
    output logic        mem_error,
    output logic        wb_valid,
    output logic        wb_regWrite,
    output logic [4:0]  wb_destReg,
    output logic [31:0] wb_result
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // M pipeline register
    logic              m_valid;
    logic [DATA_W-1:0] m_alu_out;
    logic [DATA_W-1:0] m_store_data;
    logic              m_mem_read;
    logic              m_mem_write;
    logic              m_reg_write;
    logic              m_mem_to_reg;
    logic [REG_W-1:0]  m_dest_reg;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt, wait_cnt_inc;

    logic              m_memop;
    logic              m_misaligned;

    // Request decode from the M register
    assign m_memop      = m_valid & (m_mem_read | m_mem_write);
    assign m_misaligned = m_memop & (m_alu_out[1:0] != 2'b00);

    assign dmem_req   = m_memop & ~m_misaligned & (state != ST_ERR);
    assign dmem_we    = m_mem_write;
    assign dmem_addr  = {m_alu_out[DATA_W-1:2], 2'b00};
    assign dmem_wdata = m_store_data;

    assign mem_stall      = (dmem_req & ~dmem_ready) | (state == ST_ERR);
    assign mem_memoryData = m_mem_read ? dmem_rdata : m_alu_out;
    // A misaligned op never stalls, so it sits in M for exactly one cycle
    assign mem_misaligned = m_misaligned;
    assign mem_error      = (state == ST_ERR);

    // Wait counter saturates rather than wrapping
    assign wait_cnt_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);

    // M register load / hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid      <= 1'b0;
            m_alu_out    <= '0;
            m_store_data <= '0;
            m_mem_read   <= 1'b0;
            m_mem_write  <= 1'b0;
            m_reg_write  <= 1'b0;
            m_mem_to_reg <= 1'b0;
            m_dest_reg   <= '0;
        end else if (!mem_stall) begin
            m_valid      <= ex_valid;
            m_alu_out    <= aluOutput;
            m_store_data <= exe_registerRtOrZero;
            m_mem_read   <= ex_memRead;
            m_mem_write  <= ex_memWrite;
            m_reg_write  <= ex_regWrite;
            m_mem_to_reg <= ex_memToReg;
            m_dest_reg   <= ex_destReg;
        end
    end

    // FSM state and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // FSM next state; ready in the timeout cycle wins over the error
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (dmem_req && !dmem_ready) begin
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            ST_WAIT: begin
                if (dmem_ready) begin
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt_inc == CNT_LIMIT) begin
                    state_nxt    = ST_ERR;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt_inc;
                end
            end
            ST_ERR: begin
                state_nxt = ST_ERR;
            end
            default: begin
                state_nxt    = ST_IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Writeback register: bubble while stalled, payload held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid    <= 1'b0;
            wb_regWrite <= 1'b0;
            wb_destReg  <= '0;
            wb_result   <= '0;
        end else if (!mem_stall) begin
            wb_valid    <= m_valid;
            wb_regWrite <= m_valid & m_reg_write & ~m_misaligned;
            wb_destReg  <= m_dest_reg;
            wb_result   <= m_mem_to_reg ? dmem_rdata : m_alu_out;
        end else begin
            wb_valid    <= 1'b0;
            wb_regWrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (TIMEOUT=4 instance).
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] aluOutput;
    logic [31:0] exe_registerRtOrZero;
    logic        ex_memRead;
    logic        ex_memWrite;
    logic        ex_regWrite;
    logic        ex_memToReg;
    logic [4:0]  ex_destReg;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic [31:0] mem_memoryData;
    logic        mem_misaligned;
    logic        mem_error;
    logic        wb_valid;
    logic        wb_regWrite;
    logic [4:0]  wb_destReg;
    logic [31:0] wb_result;

    int n_chk;
    int n_fail;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ex_valid             (ex_valid),
        .aluOutput            (aluOutput),
        .exe_registerRtOrZero (exe_registerRtOrZero),
        .ex_memRead           (ex_memRead),
        .ex_memWrite          (ex_memWrite),
        .ex_regWrite          (ex_regWrite),
        .ex_memToReg          (ex_memToReg),
        .ex_destReg           (ex_destReg),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_addr            (dmem_addr),
        .dmem_wdata           (dmem_wdata),
        .dmem_ready           (dmem_ready),
        .dmem_rdata           (dmem_rdata),
        .mem_stall            (mem_stall),
        .mem_memoryData       (mem_memoryData),
        .mem_misaligned       (mem_misaligned),
        .mem_error            (mem_error),
        .wb_valid             (wb_valid),
        .wb_regWrite          (wb_regWrite),
        .wb_destReg           (wb_destReg),
        .wb_result            (wb_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge to sample combinational outputs
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] addr, input logic [31:0] data,
                            input logic rd, input logic wr, input logic rw, input logic m2r,
                            input logic [4:0] dest);
        ex_valid             = v;
        aluOutput            = addr;
        exe_registerRtOrZero = data;
        ex_memRead           = rd;
        ex_memWrite          = wr;
        ex_regWrite          = rw;
        ex_memToReg          = m2r;
        ex_destReg           = dest;
    endtask

    task automatic bubble();
        drive_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        bubble();

        // Reset state
        #12;
        chk("rst_wb_valid", wb_valid, 32'h0);
        chk("rst_dmem_req", dmem_req, 32'h0);
        chk("rst_stall", mem_stall, 32'h0);
        chk("rst_error", mem_error, 32'h0);
        chk("rst_misaligned", mem_misaligned, 32'h0);
        chk("rst_wb_result", wb_result, 32'h0);
        rst_n = 1'b1;
        next();

        // Zero-wait load from 0x100
        drive_ex(1'b1, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
        next();
        bubble();
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        mid();
        chk("ld0_req", dmem_req, 32'h1);
        chk("ld0_we", dmem_we, 32'h0);
        chk("ld0_addr", dmem_addr, 32'h100);
        chk("ld0_stall", mem_stall, 32'h0);
        chk("ld0_fwd", mem_memoryData, 32'hDEADBEEF);
        next();
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        chk("ld0_wb_valid", wb_valid, 32'h1);
        chk("ld0_wb_rw", wb_regWrite, 32'h1);
        chk("ld0_wb_dest", wb_destReg, 32'd5);
        chk("ld0_wb_result", wb_result, 32'hDEADBEEF);

        // Store to 0x204, ready on the fourth request cycle
        drive_ex(1'b1, 32'h204, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        next();
        bubble();
        mid();
        chk("st_c1_req", dmem_req, 32'h1);
        chk("st_c1_we", dmem_we, 32'h1);
        chk("st_c1_addr", dmem_addr, 32'h204);
        chk("st_c1_wdata", dmem_wdata, 32'h12345678);
        chk("st_c1_stall", mem_stall, 32'h1);
        next();
        chk("st_bubble_wb_valid", wb_valid, 32'h0);
        mid();
        chk("st_c2_req", dmem_req, 32'h1);
        chk("st_c2_stall", mem_stall, 32'h1);
        next();
        mid();
        chk("st_c3_stall", mem_stall, 32'h1);
        chk("st_c3_addr_held", dmem_addr, 32'h204);
        chk("st_c3_wdata_held", dmem_wdata, 32'h12345678);
        next();
        dmem_ready = 1'b1;
        mid();
        chk("st_c4_req", dmem_req, 32'h1);
        chk("st_c4_we", dmem_we, 32'h1);
        chk("st_c4_stall", mem_stall, 32'h0);
        next();
        dmem_ready = 1'b0;
        chk("st_wb_valid", wb_valid, 32'h1);
        chk("st_wb_rw", wb_regWrite, 32'h0);
        chk("st_after_req", dmem_req, 32'h0);

        // Misaligned load at 0x102
        drive_ex(1'b1, 32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
        next();
        bubble();
        mid();
        chk("mis_pulse", mem_misaligned, 32'h1);
        chk("mis_req", dmem_req, 32'h0);
        chk("mis_stall", mem_stall, 32'h0);
        next();
        chk("mis_pulse_end", mem_misaligned, 32'h0);
        chk("mis_wb_valid", wb_valid, 32'h1);
        chk("mis_wb_rw", wb_regWrite, 32'h0);

        // Ready arrives in the cycle the counter would hit TIMEOUT
        drive_ex(1'b1, 32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);
        next();
        bubble();
        mid();
        chk("bnd_idle_stall", mem_stall, 32'h1);
        next();
        next();
        next();
        next();
        dmem_ready = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        mid();
        chk("bnd_last_stall", mem_stall, 32'h0);
        chk("bnd_last_err", mem_error, 32'h0);
        next();
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        chk("bnd_err", mem_error, 32'h0);
        chk("bnd_wb_valid", wb_valid, 32'h1);
        chk("bnd_wb_result", wb_result, 32'hCAFEF00D);
        chk("bnd_wb_dest", wb_destReg, 32'd7);

        // Timeout: ready never arrives
        drive_ex(1'b1, 32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8);
        next();
        bubble();
        next();
        next();
        next();
        next();
        chk("to_w4_err", mem_error, 32'h0);
        chk("to_w4_stall", mem_stall, 32'h1);
        next();
        chk("to_err", mem_error, 32'h1);
        chk("to_err_stall", mem_stall, 32'h1);
        chk("to_err_req", dmem_req, 32'h0);
        next();
        next();
        chk("to_err_sticky", mem_error, 32'h1);
        chk("to_err_stall_held", mem_stall, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("to_rst_err", mem_error, 32'h0);
        chk("to_rst_stall", mem_stall, 32'h0);
        chk("to_rst_wb_valid", wb_valid, 32'h0);
        #2;
        rst_n = 1'b1;

        // Reset during WAIT, then a normal load
        drive_ex(1'b1, 32'h500, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
        next();
        bubble();
        mid();
        chk("rw_idle_stall", mem_stall, 32'h1);
        next();
        chk("rw_wait_req", dmem_req, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw_rst_req", dmem_req, 32'h0);
        chk("rw_rst_stall", mem_stall, 32'h0);
        drive_ex(1'b1, 32'h600, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
        #1;
        rst_n = 1'b1;
        next();
        bubble();
        dmem_ready = 1'b1;
        dmem_rdata = 32'h0BADF00D;
        mid();
        chk("rw_new_addr", dmem_addr, 32'h600);
        chk("rw_new_stall", mem_stall, 32'h0);
        next();
        dmem_ready = 1'b0;
        chk("rw_new_wb_valid", wb_valid, 32'h1);
        chk("rw_new_wb_result", wb_result, 32'h0BADF00D);
        chk("rw_new_wb_dest", wb_destReg, 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
